// File: rtl/request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : request_scheduler
// Purpose  : Age-ordered request queue with single-entry issue register and
//            valid/ready handoff to the DRAM command sequencer.
//            Optional macro READ_PRIORITY_EN: read/fetch-first selection with
//            a starvation guard on the oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
module request_scheduler #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int QUEUE_SIZE    = 16,
   parameter int AGE_MAX       = 100
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic [1:0]                        in_opcode,
   input  logic [ADDRESS_WIDTH-1:0]          in_address,
   input  logic [31:0]                       in_time_cpu,
   output logic                              queue_full,
   output logic                              queue_empty,
   output logic [$clog2(QUEUE_SIZE+1)-1:0]   occupancy,
   output logic                              iss_valid,
   input  logic                              iss_ready,
   output logic [1:0]                        iss_opcode,
   output logic [ADDRESS_WIDTH-1:0]          iss_address,
   output logic [31:0]                       iss_time_cpu,
   output logic [$clog2(AGE_MAX+1)-1:0]      iss_age,
   output logic                              age_sat
);

   localparam int CW  = $clog2(QUEUE_SIZE+1);
   localparam int IW  = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
   localparam int AGW = $clog2(AGE_MAX+1);

   localparam logic [AGW-1:0] AMAX    = AGW'(AGE_MAX);
   localparam logic [AGW-1:0] AMAX_M1 = AGW'(AGE_MAX-1);
   localparam logic [CW-1:0]  QFULL   = CW'(QUEUE_SIZE);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_FETCH = 2'd2;
   localparam logic [1:0] OP_NOP   = 2'd3;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [1:0]               r_op   [QUEUE_SIZE];
   logic [ADDRESS_WIDTH-1:0] r_addr [QUEUE_SIZE];
   logic [31:0]              r_time [QUEUE_SIZE];
   logic [AGW-1:0]           r_age  [QUEUE_SIZE];
   logic [CW-1:0]            r_count;
   logic [0:0]               r_state;
   logic                     r_age_sat;

   logic [1:0]               w_op   [QUEUE_SIZE];
   logic [ADDRESS_WIDTH-1:0] w_addr [QUEUE_SIZE];
   logic [31:0]              w_time [QUEUE_SIZE];
   logic [AGW-1:0]           w_age  [QUEUE_SIZE];
   logic [CW-1:0]            w_tail;
   logic [CW-1:0]            w_count;
   logic                     w_rem;
   logic                     w_enq;
   logic                     w_sat_hit;
   logic [IW-1:0]            w_sel;

`ifdef READ_PRIORITY_EN
   logic          w_found;
   logic [IW-1:0] w_pri;

   // Oldest read/fetch wins unless the head entry has saturated its age.
   always_comb begin
      w_found = 1'b0;
      w_pri   = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (!w_found && (i < int'(r_count)) &&
             ((r_op[i] == OP_READ) || (r_op[i] == OP_FETCH))) begin
            w_found = 1'b1;
            w_pri   = IW'(i);
         end
      end
      w_sel = (w_found && (r_age[0] != AMAX)) ? w_pri : '0;
   end
`else
   assign w_sel = '0;
`endif

   always_comb begin
      int             j;
      logic [AGW-1:0] sa;
      j         = 0;
      sa        = '0;
      w_rem     = (r_state == IDLE) && (r_count != '0);
      w_enq     = in_valid && (in_opcode != OP_NOP) && (r_count < QFULL);
      w_tail    = r_count - CW'(w_rem);
      w_count   = w_tail + CW'(w_enq);
      w_sat_hit = 1'b0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         // Slots at and above the removed index pull from their upper neighbour.
         j = i;
         if (w_rem && (i >= int'(w_sel)) && (i < QUEUE_SIZE-1))
            j = i + 1;
         w_op[i]   = r_op[IW'(j)];
         w_addr[i] = r_addr[IW'(j)];
         w_time[i] = r_time[IW'(j)];
         w_age[i]  = r_age[i];
         if (i < int'(w_tail)) begin
            sa = r_age[IW'(j)];
            if (sa == AMAX_M1)
               w_sat_hit = 1'b1;
            w_age[i] = (sa < AMAX) ? sa + 1'b1 : sa;
         end
         if (w_enq && (i == int'(w_tail))) begin
            w_op[i]   = in_opcode;
            w_addr[i] = in_address;
            w_time[i] = in_time_cpu;
            w_age[i]  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            r_op[i]   <= OP_NOP;
            r_addr[i] <= '0;
            r_time[i] <= '0;
            r_age[i]  <= '0;
         end
         r_count      <= '0;
         r_state      <= IDLE;
         r_age_sat    <= 1'b0;
         iss_opcode   <= OP_NOP;
         iss_address  <= '0;
         iss_time_cpu <= '0;
         iss_age      <= '0;
      end else begin
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            r_op[i]   <= w_op[i];
            r_addr[i] <= w_addr[i];
            r_time[i] <= w_time[i];
            r_age[i]  <= w_age[i];
         end
         r_count   <= w_count;
         r_age_sat <= w_sat_hit;
         case (r_state)
            IDLE: begin
               if (w_rem) begin
                  iss_opcode   <= r_op[w_sel];
                  iss_address  <= r_addr[w_sel];
                  iss_time_cpu <= r_time[w_sel];
                  iss_age      <= r_age[w_sel];
                  r_state      <= PRESENT;
               end
            end
            PRESENT: begin
               if (iss_ready)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign iss_valid   = (r_state == PRESENT);
   assign queue_full  = (r_count == QFULL);
   assign queue_empty = (r_count == '0);
   assign occupancy   = r_count;
   assign age_sat     = r_age_sat;

endmodule
`default_nettype wire

// File: tb/tb_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_scheduler
// Purpose  : Directed, table-driven self-checking bench for request_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  in_opcode;
   logic [31:0] in_address;
   logic [31:0] in_time_cpu;
   logic        queue_full;
   logic        queue_empty;
   logic [4:0]  occupancy;
   logic        iss_valid;
   logic        iss_ready;
   logic [1:0]  iss_opcode;
   logic [31:0] iss_address;
   logic [31:0] iss_time_cpu;
   logic [6:0]  iss_age;
   logic        age_sat;

   request_scheduler #(.ADDRESS_WIDTH(32), .QUEUE_SIZE(16), .AGE_MAX(100)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_address(in_address), .in_time_cpu(in_time_cpu),
      .queue_full(queue_full), .queue_empty(queue_empty), .occupancy(occupancy),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
      .iss_address(iss_address), .iss_time_cpu(iss_time_cpu), .iss_age(iss_age),
      .age_sat(age_sat)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] t;
      logic        exp_issue;
   } vec_t;
   vec_t tbl[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic enq(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] t);
      in_valid    = 1'b1;
      in_opcode   = op;
      in_address  = addr;
      in_time_cpu = t;
      step();
      in_valid    = 1'b0;
      in_opcode   = 2'd3;
   endtask

   task automatic drain_check(input string nm);
      int guard;
      guard     = 0;
      iss_ready = 1'b1;
      while (exp_q.size() > 0 && guard < 200) begin
         if (iss_valid) chk(nm, iss_address, exp_q.pop_front());
         step();
         guard++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: actual=%0d pending required=0 pending", nm, exp_q.size());
         exp_q.delete();
      end
      iss_ready = 1'b0;
   endtask

   initial begin
      int pulses;
      int first_k;

      tbl[0] = '{2'd0, 32'h0000_1000, 32'd10,          1'b1};
      tbl[1] = '{2'd1, 32'hDEAD_BEEF, 32'd20,          1'b1};
      tbl[2] = '{2'd2, 32'h0000_0000, 32'hFFFF_FFFF,   1'b1};
      tbl[3] = '{2'd3, 32'h0000_5555, 32'd7,           1'b0};
      tbl[4] = '{2'd0, 32'hFFFF_FFFF, 32'd123,         1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_opcode = 2'd3;
      in_address = '0; in_time_cpu = '0; iss_ready = 1'b0;
      step(); step();
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_iss_opcode", iss_opcode, 3);
      chk("rst_iss_address", iss_address, 0);
      chk("rst_iss_time", iss_time_cpu, 0);
      chk("rst_iss_age", iss_age, 0);
      chk("rst_full", queue_full, 0);
      chk("rst_empty", queue_empty, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_age_sat", age_sat, 0);
      rst_n = 1'b1;
      step();

      // Single requests: selected one edge after enqueue, accepted the next.
      iss_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         enq(tbl[v].op, tbl[v].addr, tbl[v].t);
         chk("single_occ_after_enq", occupancy, {4'd0, tbl[v].exp_issue});
         chk("single_valid_early", iss_valid, 0);
         step();
         chk("single_valid", iss_valid, tbl[v].exp_issue);
         if (tbl[v].exp_issue) begin
            chk("single_addr", iss_address, tbl[v].addr);
            chk("single_op", iss_opcode, tbl[v].op);
            chk("single_time", iss_time_cpu, tbl[v].t);
            chk("single_age", iss_age, 0);
         end
         step();
         chk("single_valid_done", iss_valid, 0);
         chk("single_occ_done", occupancy, 0);
         chk("single_empty_done", queue_empty, 1);
      end
      iss_ready = 1'b0;

      // Fill to full, then the simultaneous enqueue/selection corner cases.
      for (int i = 0; i < 16; i++) enq(2'd1, 32'h100 + i, i);
      chk("fill_occ15", occupancy, 15);
      chk("fill_notfull", queue_full, 0);
      chk("fill_issue0", iss_address, 32'h100);
      enq(2'd1, 32'h110, 16);
      chk("fill_occ16", occupancy, 16);
      chk("fill_full", queue_full, 1);
      enq(2'd1, 32'h111, 17);
      enq(2'd1, 32'h112, 18);
      chk("fill_ignored_occ", occupancy, 16);
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      chk("bubble_valid", iss_valid, 0);
      chk("bubble_occ", occupancy, 16);
      enq(2'd1, 32'h200, 19);
      chk("full_simul_occ", occupancy, 15);
      chk("full_simul_valid", iss_valid, 1);
      chk("full_simul_addr", iss_address, 32'h101);
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      enq(2'd1, 32'h300, 20);
      chk("simul15_occ", occupancy, 15);
      chk("simul15_addr", iss_address, 32'h102);
      for (int i = 2; i <= 16; i++) exp_q.push_back(32'h100 + i);
      exp_q.push_back(32'h300);
      drain_check("fill_drain");
      chk("fill_drain_occ", occupancy, 0);
      chk("fill_drain_empty", queue_empty, 1);
      step();
      chk("fill_drain_idle", iss_valid, 0);

      // Aging: B sits at index 0 while A is held in the issue register.
      enq(2'd1, 32'hA0, 1);
      enq(2'd1, 32'hB0, 2);
      pulses = 0; first_k = -1;
      for (int k = 1; k <= 110; k++) begin
         step();
         if (age_sat) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
      end
      chk("age_sat_pulses", pulses, 1);
      chk("age_sat_cycle", first_k, 100);
      iss_ready = 1'b1;
      step();
      chk("age_bubble", iss_valid, 0);
      step();
      chk("age_valid", iss_valid, 1);
      chk("age_addr", iss_address, 32'hB0);
      chk("age_value", iss_age, 100);
      step();
      iss_ready = 1'b0;
      chk("age_drained", queue_empty, 1);

      // Selection order: write A, write B, read C behind a presented request.
      enq(2'd1, 32'hD0, 0);
      enq(2'd1, 32'hA1, 0);
      enq(2'd1, 32'hB1, 0);
      enq(2'd0, 32'hC1, 0);
`ifdef READ_PRIORITY_EN
      exp_q = '{32'hD0, 32'hC1, 32'hA1, 32'hB1};
`else
      exp_q = '{32'hD0, 32'hA1, 32'hB1, 32'hC1};
`endif
      drain_check("order");
      step();

      // Same order test with the head entry aged to saturation.
      enq(2'd1, 32'hD2, 0);
      enq(2'd1, 32'hA2, 0);
      repeat (97) step();
      enq(2'd1, 32'hB2, 0);
      enq(2'd0, 32'hC2, 0);
      step(); step();
`ifdef READ_PRIORITY_EN
      exp_q = '{32'hD2, 32'hA2, 32'hC2, 32'hB2};
`else
      exp_q = '{32'hD2, 32'hA2, 32'hB2, 32'hC2};
`endif
      drain_check("order_aged");
      step();

      // Asynchronous reset mid-PRESENT with five entries queued.
      for (int i = 0; i < 6; i++) enq(2'd1, 32'h400 + i, i);
      chk("prerst_occ", occupancy, 5);
      chk("prerst_valid", iss_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", iss_valid, 0);
      chk("async_rst_occ", occupancy, 0);
      chk("async_rst_empty", queue_empty, 1);
      chk("async_rst_opcode", iss_opcode, 3);
      step();
      rst_n = 1'b1;
      step(); step();
      chk("postrst_valid", iss_valid, 0);
      chk("postrst_occ", occupancy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
